// File: rtl/axi_pipeline_adder.sv
// Ready/valid streaming adder: a+b is computed CHUNK_SZ bits per stage with the
// carry rippled through registers, operands and user sideband travel alongside.
module axi_pipeline_adder #(
  parameter int DWIDTH   = 32,
  parameter int CHUNK_SZ = 8,
  parameter int UWIDTH   = 9
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              s_axi_valid,
  output logic              s_axi_ready,
  input  logic [DWIDTH-1:0] s_axi_data_a,
  input  logic [DWIDTH-1:0] s_axi_data_b,
  input  logic [UWIDTH-1:0] s_axi_user,
  output logic              m_axi_valid,
  input  logic              m_axi_ready,
  output logic [DWIDTH-1:0] m_axi_data_a,
  output logic [DWIDTH-1:0] m_axi_data_b,
  output logic [DWIDTH-1:0] m_axi_data_result,
  output logic              m_axi_data_carry,
  output logic [UWIDTH-1:0] m_axi_user
);

  localparam int NUM_STAGES = DWIDTH / CHUNK_SZ;
  localparam int LAST       = NUM_STAGES - 1;

  typedef struct packed {
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic [UWIDTH-1:0] user;
    logic [DWIDTH-1:0] res;
    logic              carry;
  } beat_t;

  logic [NUM_STAGES-1:0] valid_q;
  beat_t                 stage_q   [NUM_STAGES];

  logic [NUM_STAGES-1:0] stage_ready;
  logic                  ready_chain;
  logic [NUM_STAGES-1:0] up_valid;
  beat_t                 up        [NUM_STAGES];
  beat_t                 nxt       [NUM_STAGES];
  logic [CHUNK_SZ:0]     chunk_sum [NUM_STAGES];

  // A stage can load unless it is full and everything downstream of it is full
  // with the consumer stalled; this lets bubbles collapse.
  always_comb begin
    stage_ready = '0;
    ready_chain = m_axi_ready;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      // NOTE: blocking assignments are correct in combinational logic; the
      // running chain value must be visible to the next loop iteration.
      ready_chain    = ready_chain | ~valid_q[k];
      stage_ready[k] = ready_chain;
    end
  end

  assign s_axi_ready = stage_ready[0];

  always_comb begin
    up_valid    = '0;
    up_valid[0] = s_axi_valid;
    up[0]       = '{a: s_axi_data_a, b: s_axi_data_b, user: s_axi_user,
                    res: '0, carry: 1'b0};
    for (int k = 1; k < NUM_STAGES; k++) begin
      up_valid[k] = valid_q[k-1];
      up[k]       = stage_q[k-1];
    end
    for (int k = 0; k < NUM_STAGES; k++) begin
      chunk_sum[k] = {1'b0, up[k].a[k*CHUNK_SZ +: CHUNK_SZ]}
                   + {1'b0, up[k].b[k*CHUNK_SZ +: CHUNK_SZ]}
                   + (CHUNK_SZ+1)'(up[k].carry);
      nxt[k]       = up[k];
      nxt[k].res[k*CHUNK_SZ +: CHUNK_SZ] = chunk_sum[k][CHUNK_SZ-1:0];
      nxt[k].carry = chunk_sum[k][CHUNK_SZ];
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_q <= '0;
      // NOTE: datapath registers are reset too, so outputs read all-zero while
      // idle after reset; the array is small so this costs little.
      for (int k = 0; k < NUM_STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (stage_ready[k]) begin
          valid_q[k] <= up_valid[k];
          if (up_valid[k]) stage_q[k] <= nxt[k];
        end
      end
    end
  end

  assign m_axi_valid       = valid_q[LAST];
  assign m_axi_data_a      = stage_q[LAST].a;
  assign m_axi_data_b      = stage_q[LAST].b;
  assign m_axi_data_result = stage_q[LAST].res;
  assign m_axi_data_carry  = stage_q[LAST].carry;
  assign m_axi_user        = stage_q[LAST].user;

endmodule

// File: tb/tb_axi_pipeline_adder.sv
// Self-checking bench for axi_pipeline_adder: directed vector table, stall and
// reset sequences, and randomized traffic against an arithmetic scoreboard.
module tb_axi_pipeline_adder;

  localparam int DW = 32;
  localparam int UW = 9;

  logic          clk = 1'b0;
  logic          areset;
  logic          s_axi_valid;
  logic          s_axi_ready;
  logic [DW-1:0] s_axi_data_a, s_axi_data_b;
  logic [UW-1:0] s_axi_user;
  logic          m_axi_valid;
  logic          m_axi_ready;
  logic [DW-1:0] m_axi_data_a, m_axi_data_b, m_axi_data_result;
  logic          m_axi_data_carry;
  logic [UW-1:0] m_axi_user;

  axi_pipeline_adder #(.DWIDTH(DW), .CHUNK_SZ(8), .UWIDTH(UW)) dut (
    .clk(clk), .areset(areset),
    .s_axi_valid(s_axi_valid), .s_axi_ready(s_axi_ready),
    .s_axi_data_a(s_axi_data_a), .s_axi_data_b(s_axi_data_b), .s_axi_user(s_axi_user),
    .m_axi_valid(m_axi_valid), .m_axi_ready(m_axi_ready),
    .m_axi_data_a(m_axi_data_a), .m_axi_data_b(m_axi_data_b),
    .m_axi_data_result(m_axi_data_result), .m_axi_data_carry(m_axi_data_carry),
    .m_axi_user(m_axi_user)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a, b;
    logic [UW-1:0] user;
    logic [DW-1:0] res;
    logic          carry;
  } vec_t;

  int     tests = 0;
  int     failed = 0;
  vec_t   sb [$];
  int     out_cyc [$];
  int     cyc = 0;
  logic   last_in_fire = 1'b0;
  logic   prev_stall = 1'b0;
  logic [127:0] prev_bundle = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [DW-1:0] a, b, input logic [UW-1:0] user);
    vec_t v;
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    v.a = a; v.b = b; v.user = user; v.res = s[DW-1:0]; v.carry = s[DW];
    return v;
  endfunction

  function automatic logic [127:0] out_bundle();
    return {m_axi_valid, m_axi_data_a, m_axi_data_b, m_axi_data_result,
            m_axi_data_carry, m_axi_user};
  endfunction

  // Called at a falling edge; samples handshakes 1ns before the rising edge.
  task automatic tick();
    logic in_fire, out_fire;
    vec_t e;
    #4;
    in_fire  = !areset && s_axi_valid && s_axi_ready;
    out_fire = !areset && m_axi_valid && m_axi_ready;
    last_in_fire = in_fire;
    if (prev_stall && !areset) check("hold_stable", out_bundle(), prev_bundle);
    prev_stall  = !areset && m_axi_valid && !m_axi_ready;
    prev_bundle = out_bundle();
    if (out_fire) begin
      out_cyc.push_back(cyc);
      if (sb.size() == 0) check("sb_unexpected_beat", m_axi_valid, 1'b0);
      else begin
        e = sb.pop_front();
        check("sb_result", m_axi_data_result, e.res);
        check("sb_carry", m_axi_data_carry, e.carry);
        check("sb_a", m_axi_data_a, e.a);
        check("sb_b", m_axi_data_b, e.b);
        check("sb_user", m_axi_user, e.user);
      end
    end
    if (in_fire) sb.push_back(model(s_axi_data_a, s_axi_data_b, s_axi_user));
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, b, input logic [UW-1:0] u);
    s_axi_valid = v; s_axi_data_a = a; s_axi_data_b = b; s_axi_user = u;
  endtask

  task automatic drain(input string name);
    s_axi_valid = 1'b0;
    for (int i = 0; i < 60 && sb.size() > 0; i++) begin
      m_axi_ready = 1'b1;
      tick();
    end
    check(name, sb.size(), 0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int n;
    m_axi_ready = 1'b1;
    drive(1'b1, v.a, v.b, v.user);
    tick();
    check({name, "_accept"}, last_in_fire, 1'b1);
    s_axi_valid = 1'b0;
    n = 1;
    while (!m_axi_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, 4);
    check({name, "_result"}, m_axi_data_result, v.res);
    check({name, "_carry"}, m_axi_data_carry, v.carry);
    check({name, "_a"}, m_axi_data_a, v.a);
    check({name, "_b"}, m_axi_data_b, v.b);
    check({name, "_user"}, m_axi_user, v.user);
    tick();
    check({name, "_drained"}, m_axi_valid, 1'b0);
  endtask

  vec_t vecs [7];

  initial begin
    int j, outs0;
    vecs[0] = '{a: 32'h12345678, b: 32'h11111111, user: 9'h0A5, res: 32'h23456789, carry: 1'b0};
    vecs[1] = '{a: 32'hFFFFFFFF, b: 32'h00000001, user: 9'h101, res: 32'h00000000, carry: 1'b1};
    vecs[2] = '{a: 32'h000000FF, b: 32'h00000001, user: 9'h002, res: 32'h00000100, carry: 1'b0};
    vecs[3] = '{a: 32'h00FFFF00, b: 32'h00000100, user: 9'h0FF, res: 32'h01000000, carry: 1'b0};
    vecs[4] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, user: 9'h1FF, res: 32'hFFFFFFFE, carry: 1'b1};
    vecs[5] = '{a: 32'h80000000, b: 32'h80000000, user: 9'h000, res: 32'h00000000, carry: 1'b1};
    vecs[6] = '{a: 32'h0000FFFF, b: 32'h00FF0001, user: 9'h155, res: 32'h01000000, carry: 1'b0};

    areset = 1'b1;
    m_axi_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("reset_m_valid", m_axi_valid, 1'b0);
    check("reset_result", m_axi_data_result, 32'h0);
    areset = 1'b0;
    @(negedge clk);
    check("post_reset_s_ready", s_axi_ready, 1'b1);
    check("post_reset_m_valid", m_axi_valid, 1'b0);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // 16 back-to-back beats, last flag on beat 15 only.
    out_cyc.delete();
    m_axi_ready = 1'b1;
    j = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(i), DW'(16 * i), {(i == 15), 8'(i)});
      tick();
      if (last_in_fire) j++;
    end
    check("b2b_accepted", j, 16);
    drain("b2b_drain");
    check("b2b_out_count", out_cyc.size(), 16);
    if (out_cyc.size() == 16) check("b2b_throughput", out_cyc[15] - out_cyc[0], 15);

    // Stall with 6 offered beats, then random throttle.
    out_cyc.delete();
    m_axi_ready = 1'b0;
    j = 0;
    for (int i = 0; i < 8; i++) begin
      drive(j < 6, 32'h0100_0000 * j + $urandom, $urandom, 9'(j));
      tick();
      if (last_in_fire) j++;
    end
    check("stall_accepted", j, 4);
    check("stall_s_ready", s_axi_ready, 1'b0);
    check("stall_m_valid", m_axi_valid, 1'b1);
    for (int i = 0; i < 100 && (j < 6 || sb.size() > 0); i++) begin
      m_axi_ready = ($urandom_range(0, 4) != 0);
      if (!(s_axi_valid && j < 6)) drive(j < 6, $urandom, $urandom, 9'(j));
      tick();
      if (last_in_fire) begin
        j++;
        drive(j < 6, $urandom, $urandom, 9'(j));
      end
    end
    check("throttle_all_in", j, 6);
    drain("throttle_drain");
    check("throttle_out_count", out_cyc.size(), 6);

    // Reset with beats in flight.
    m_axi_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, 9'($urandom));
      tick();
    end
    s_axi_valid = 1'b0;
    areset = 1'b1;
    #1;
    check("mid_reset_m_valid", m_axi_valid, 1'b0);
    check("mid_reset_outputs", {m_axi_data_a, m_axi_data_b, m_axi_data_result,
                                m_axi_data_carry, m_axi_user}, '0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    tick();
    check("after_reset_s_ready", s_axi_ready, 1'b1);
    check("after_reset_m_valid", m_axi_valid, 1'b0);
    run_vec("post_reset", '{a: 32'd5, b: 32'd7, user: 9'h000, res: 32'd12, carry: 1'b0});

    // Randomized traffic with random backpressure.
    out_cyc.delete();
    j = 0;
    for (int i = 0; i < 300; i++) begin
      m_axi_ready = ($urandom_range(0, 9) < 7);
      if (!s_axi_valid || last_in_fire)
        drive($urandom_range(0, 9) < 7, $urandom, $urandom, 9'($urandom));
      last_in_fire = 1'b0;
      tick();
      if (last_in_fire) j++;
    end
    outs0 = j;
    drain("random_drain");
    check("random_out_count", out_cyc.size(), outs0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
